// File: rtl/regfile_sb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb_pkg
// Purpose  : Shared defaults and helpers for the scoreboarded register file.
//            Optional feature macro used by this block: REGFILE_SB_BYPASS_EN
// Revision : 1.0 - initial release
// ============================================================================
package regfile_sb_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 4;
  localparam int DEF_NUM_REGS = 15;
  localparam int DEF_PC_IDX   = 15;
  localparam int DEF_NUM_RD   = 3;
  localparam int DEF_CNT_W    = 4;

  // Index that returns the externally supplied PC value instead of storage
  localparam int C_PC_INDEX   = DEF_PC_IDX;

  // True when addr names a physically stored register
  function automatic logic valid_idx(input int unsigned addr,
                                     input int unsigned num_regs = DEF_NUM_REGS);
    return addr < num_regs;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_sb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb_scoreboard
// Purpose  : Load scoreboard - one pending bit per stored register, a count of
//            outstanding loads and a one-cycle error pulse on illegal sets.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_sb_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                set_i,
  input  logic [ADDR_W-1:0]   set_addr_i,
  input  logic                clr_i,
  input  logic [ADDR_W-1:0]   clr_addr_i,
  output logic [NUM_REGS-1:0] pending_o,
  output logic [CNT_W-1:0]    pend_cnt_o,
  output logic                pend_err_o
);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [NUM_REGS-1:0] w_set_oh, w_clr_oh;
  logic                w_inc, w_dec;

  // One-hot decode of set/clear requests; out-of-range addresses decode to zero
  always_comb begin
    w_set_oh = '0;
    w_clr_oh = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_set_oh[i] = set_i && (set_addr_i == ADDR_W'(i));
      w_clr_oh[i] = clr_i && (clr_addr_i == ADDR_W'(i));
    end
  end

  // Next pending vector, count delta and error; set wins over a same-address clear
  always_comb begin
    pending_d = (pending_q & ~w_clr_oh) | w_set_oh;
    w_inc     = |(w_set_oh & ~pending_q);
    w_dec     = |(w_clr_oh & pending_q & ~w_set_oh);
    cnt_d     = cnt_q + {{(CNT_W-1){1'b0}}, w_inc} - {{(CNT_W-1){1'b0}}, w_dec};
    err_d     = set_i && (!valid_idx(32'(set_addr_i), NUM_REGS) ||
                          (|(w_set_oh & pending_q & ~w_clr_oh)));
  end

  // Scoreboard state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign pending_o  = pending_q;
  assign pend_cnt_o = cnt_q;
  assign pend_err_o = err_q;

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb
// Purpose  : Multi-read, dual-write register file with load scoreboard and a
//            PC pseudo-register. Define REGFILE_SB_BYPASS_EN to forward
//            same-cycle write data and write-back clears to the read ports.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int PC_IDX   = C_PC_INDEX,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     we_a,
  input  logic [ADDR_W-1:0]        wa_a,
  input  logic [DATA_W-1:0]        wd_a,
  input  logic                     we_b,
  input  logic [ADDR_W-1:0]        wa_b,
  input  logic [DATA_W-1:0]        wd_b,
  input  logic                     pend_set,
  input  logic [ADDR_W-1:0]        pend_addr,
  input  logic [DATA_W-1:0]        pc_in,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] rd,
  output logic [NUM_RD-1:0]        busy,
  output logic [CNT_W-1:0]         pend_cnt,
  output logic                     pend_err
);

  logic [DATA_W-1:0]   mem_q [NUM_REGS];
  logic [DATA_W-1:0]   mem_d [NUM_REGS];
  logic [NUM_REGS-1:0] w_pending;

  regfile_sb_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS),
    .CNT_W    (CNT_W)
  ) u_scoreboard (
    .clk        (clk),
    .reset_n    (reset_n),
    .set_i      (pend_set),
    .set_addr_i (pend_addr),
    .clr_i      (we_b),
    .clr_addr_i (wa_b),
    .pending_o  (w_pending),
    .pend_cnt_o (pend_cnt),
    .pend_err_o (pend_err)
  );

  // Write merge: port A is applied last so it wins an address collision
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      mem_d[i] = mem_q[i];
      if (we_b && (wa_b == ADDR_W'(i))) mem_d[i] = wd_b;
      if (we_a && (wa_a == ADDR_W'(i))) mem_d[i] = wd_a;
    end
  end

  // Register storage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= mem_d[i];
    end
  end

  generate
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_port
      logic [ADDR_W-1:0] w_addr;
      logic [DATA_W-1:0] w_data;
      logic              w_busy;

      assign w_addr = ra[p*ADDR_W +: ADDR_W];

      // Combinational read: PC pseudo-register, stored register or zero
      always_comb begin
        w_data = '0;
        w_busy = 1'b0;
        if (w_addr == ADDR_W'(PC_IDX)) begin
          w_data = pc_in;
        end else if (valid_idx(32'(w_addr), NUM_REGS)) begin
          for (int j = 0; j < NUM_REGS; j++) begin
            if (w_addr == ADDR_W'(j)) begin
              w_data = mem_q[j];
              w_busy = w_pending[j];
            end
          end
`ifdef REGFILE_SB_BYPASS_EN
          // Forwarding is suppressed under reset so reads stay at zero
          if (reset_n && we_b && (wa_b == w_addr)) begin
            w_data = wd_b;
            if (!(pend_set && (pend_addr == w_addr))) w_busy = 1'b0;
          end
          if (reset_n && we_a && (wa_a == w_addr)) w_data = wd_a;
`endif
        end
      end

      assign rd[p*DATA_W +: DATA_W] = w_data;
      assign busy[p]                = w_busy;
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised, multi-read-port, dual-write-port register file for the multi-cycle core.
- Adds a load scoreboard: a pending bit per register, set when a load issues and cleared when the load writes back. Read ports report a busy flag so the controller can stall.
- The PC index reads an externally supplied value, normally PC+8.
- Sits in the datapath between decode/operand fetch and the ALU/memory writeback paths.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 4, register address width.
- NUM_REGS, 15, number of stored registers, indices 0..NUM_REGS-1.
- PC_IDX, 15, index that reads pc_in instead of storage; must be >= NUM_REGS.
- NUM_RD, 3, number of combinational read ports.
- CNT_W, 4, width of the outstanding-load counter; must satisfy 2^CNT_W > NUM_REGS.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- we_a  in  1  write enable, ALU/result port.
- wa_a  in  ADDR_W  write address, port A.
- wd_a  in  DATA_W  write data, port A.
- we_b  in  1  write enable, load-writeback port.
- wa_b  in  ADDR_W  write address, port B.
- wd_b  in  DATA_W  write data, port B.
- pend_set  in  1  load issued; mark pend_addr pending.
- pend_addr  in  ADDR_W  destination register of the issued load.
- pc_in  in  DATA_W  value returned for reads of PC_IDX.
- ra  in  NUM_RD*ADDR_W  packed read addresses; port i is bits [i*ADDR_W +: ADDR_W].
- rd  out  NUM_RD*DATA_W  packed read data.
- busy  out  NUM_RD  busy[i] = pending bit of ra port i.
- pend_cnt  out  CNT_W  number of registers currently pending.
- pend_err  out  1  registered one-cycle pulse on an illegal pend_set.

Behaviour:
- Reset (reset_n low, asynchronous):
  - All stored registers, pending bits and pend_cnt go to 0; pend_err goes to 0.
  - rd[i] reads 0, or pc_in when ra[i]==PC_IDX; busy is all 0.
  - Deassertion takes effect on the next clk edge. A reset asserted mid-operation discards all pending state immediately.
- Reads: fully combinational, zero latency.
  - ra==PC_IDX gives pc_in and busy=0.
  - ra>=NUM_REGS and !=PC_IDX gives 0 and busy=0.
- Writes: on posedge clk.
  - Port A writes when we_a and wa_a<NUM_REGS.
  - Port B writes when we_b and wa_b<NUM_REGS.
  - Writes to PC_IDX or out-of-range indices are silently dropped.
  - Same address on both ports in the same cycle: port A data wins; port B still clears the pending bit.
- Scoreboard, on posedge:
  - we_b on a valid address clears pending[wa_b].
  - pend_set on a valid address sets pending[pend_addr].
  - Set and clear on the same address in the same cycle: set wins (back-to-back load), and pend_cnt is unchanged.
  - A port A write does not touch pending bits.
- pend_cnt:
  - +1 on an effective set of a clear bit; -1 on an effective clear of a set bit; net 0 when both occur on different addresses.
  - Never wraps, since it is bounded by NUM_REGS.
- pend_err is 1 for exactly the cycle after pend_set when either:
  - pend_addr is already pending and is not being cleared that cycle, or
  - pend_addr is PC_IDX or out of range.
  - In both cases the pending state is unchanged.
- we_b to a register that is not pending: the write is performed, nothing is flagged, and the count is unchanged.

Optional Feature:
- Macro: REGFILE_SB_BYPASS_EN.
- Defined:
  - Same-cycle write forwarding: if ra[i] matches an enabled, valid write address, rd[i] returns that write data (A over B).
  - busy[i] reads 0 when ra[i] matches wa_b with we_b high, unless pend_set targets the same address in that cycle.
- Undefined:
  - rd returns the stored value; new data is visible the cycle after the write.
  - busy reflects the registered pending bits only.

Decomposition:
- Package regfile_sb_pkg holds:
  - default DATA_W, ADDR_W, NUM_REGS, PC_IDX, NUM_RD;
  - a localparam for the PC index;
  - a helper function valid_idx(addr), returning addr < NUM_REGS.
- One sub-module, regfile_sb_scoreboard: pending bit vector, pend_cnt and pend_err.
  - Inputs: set/clear requests and addresses.
  - Outputs: the pending vector and pend_cnt.
- Storage and read muxing stay in the top level.

Test Plan:
- Reset then read:
  - reset_n=0 mid-write, ra={15,3,0}, pc_in=0x108 -> rd={0x108,0,0}, busy=0, pend_cnt=0.
- Dual write collision:
  - we_a=we_b=1, wa_a=wa_b=5, wd_a=0xAAAA0000, wd_b=0x5555 -> next cycle r5=0xAAAA0000.
  - If r5 was pending, the pending bit clears and pend_cnt decrements.
- Load scoreboard:
  - pend_set r2, then 3 idle cycles -> busy=1 for ra=2 and pend_cnt=1.
  - we_b wa_b=2 wd_b=0x1234 -> next cycle busy=0, rd=0x1234, pend_cnt=0.
- Set/clear same cycle:
  - r7 pending; pend_set r7 and we_b wa_b=7 together -> r7 written, still pending, pend_cnt unchanged, pend_err=0.
- Errors:
  - pend_set on already-pending r4 -> pend_err=1 for one cycle, pend_cnt unchanged.
  - pend_set r15 -> pend_err=1.
  - we_a wa_a=15 -> no state change.
- Bypass (macro defined):
  - we_a wa_a=9 wd_a=0xDEAD with ra=9 -> rd=0xDEAD in the same cycle.
  - Macro undefined -> old value this cycle, 0xDEAD next cycle.
